// File: rtl/mem_burst_pkg.sv
// rtl/mem_burst_pkg.sv - shared types and constants for the line burst memory
// Purpose: FSM state encoding, line/beat geometry and the beat word-address helper.
// Ports: none (package).
package mem_burst_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WBURST = 3'd1,
    S_RWAIT  = 3'd2,
    S_RBURST = 3'd3,
    S_DONE   = 3'd4
  } state_e;

  localparam int BEAT_BITS  = 3;
  localparam int BEATS      = 8;
  localparam int LINE_BYTES = 64;

  // 64-bit word index of one beat: line number from the byte address, beat as the low bits.
  // Offset bits [5:0] of the byte address drop out in the division.
  function automatic logic [31:0] beat_word(input logic [31:0] byte_addr,
                                            input logic [BEAT_BITS-1:0] beat);
    return (byte_addr / LINE_BYTES) * BEATS + 32'(beat);
  endfunction

endpackage

// File: rtl/line_burst_mem_if.sv
// rtl/line_burst_mem_if.sv - cache-side burst handshake bundle
// Purpose: groups the line-fill/write-back request and response signals.
// Signals: req, wr, addr[ADDR_BITS], wdata[64] (cache -> memory);
//          ready, rvalid, rdata[64], busy (memory -> cache).
// Modports: master = cache engine, slave = memory backend.
interface line_burst_mem_if #(
  parameter int ADDR_BITS = 16
);
  logic                 req;
  logic                 wr;
  logic [ADDR_BITS-1:0] addr;
  logic [63:0]          wdata;
  logic                 ready;
  logic                 rvalid;
  logic [63:0]          rdata;
  logic                 busy;

  modport master (output req, wr, addr, wdata, input ready, rvalid, rdata, busy);
  modport slave  (input req, wr, addr, wdata, output ready, rvalid, rdata, busy);
endinterface

// File: rtl/sp_bram64.sv
// rtl/sp_bram64.sv - single-port 64-bit BRAM with registered read
// Purpose: line storage; contents are never reset, only the read register is.
// Ports: clk, rst (async active-high, clears rdata_o), we_i (write enable), re_i (read enable),
//        addr_i[AW] word index, wdata_i[64], rdata_o[64] (valid the cycle after re_i, held otherwise).
module sp_bram64 #(
  parameter int AW = 13
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we_i,
  input  logic          re_i,
  input  logic [AW-1:0] addr_i,
  input  logic [63:0]   wdata_i,
  output logic [63:0]   rdata_o
);
  logic [63:0] mem_q [2**AW];
  logic [63:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end

  // Read register only loads on re_i so the last beat stays on rdata between bursts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/line_burst_mem.sv
// rtl/line_burst_mem.sv - 8-beat cache-line burst memory backend
// Purpose: accepts write bursts (victim write-back) and read bursts (line fill) of whole
//          64-byte lines from the L1 line engine and keeps them in an internal BRAM.
// Ports: clk, rst (async active-high), bus (line_burst_mem_if.slave: req/wr/addr/wdata in,
//        ready/rvalid/rdata/busy out).
// Optional: BURST_MEM_STALL_EN adds an 8-bit LFSR that injects ready/rvalid wait states.
module line_burst_mem
  import mem_burst_pkg::*;
#(
  parameter int ADDR_BITS = 16,
  parameter int BEATS     = 8,
  parameter int RD_LAT    = 2
) (
  input  logic            clk,
  input  logic            rst,
  line_burst_mem_if.slave bus
);
  localparam int                   WORD_BITS = ADDR_BITS - 3;
  localparam logic [BEAT_BITS-1:0] LAST_BEAT = BEAT_BITS'(BEATS - 1);
  localparam logic [2:0]           LAT_INIT  = 3'(RD_LAT - 1);

  state_e               state_q, state_d;
  logic [BEAT_BITS-1:0] beat_q, beat_d;
  logic [2:0]           lat_q, lat_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic                 stall;
  logic                 mem_we, mem_re;
  logic                 ready, rvalid;
  logic [BEAT_BITS-1:0] mem_beat;
  logic [WORD_BITS-1:0] mem_addr;

`ifdef BURST_MEM_STALL_EN
  logic [7:0] lfsr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    lfsr_q <= 8'h5A;
    else if (state_q != S_IDLE) lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  assign stall = (lfsr_q[1:0] == 2'b00);
`else
  assign stall = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      beat_q  <= '0;
      lat_q   <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      lat_q   <= lat_d;
      addr_q  <= addr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    lat_d   = lat_q;
    addr_d  = addr_q;
    mem_we  = 1'b0;
    mem_re  = 1'b0;
    ready   = 1'b0;
    rvalid  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.req) begin
          addr_d = bus.addr;
          beat_d = '0;
          if (bus.wr) begin
            state_d = S_WBURST;
          end else begin
            state_d = S_RWAIT;
            lat_d   = LAT_INIT;
          end
        end
      end
      S_WBURST: begin
        if (!bus.req) begin
          state_d = S_IDLE;
        end else if (!stall) begin
          ready  = 1'b1;
          mem_we = 1'b1;
          beat_d = beat_q + 1'b1;
          if (beat_q == LAST_BEAT) state_d = S_DONE;
        end
      end
      S_RWAIT: begin
        if (!bus.req) begin
          state_d = S_IDLE;
        end else if (lat_q == '0) begin
          // Fetch beat 0 now so it sits on rdata the first RBURST cycle.
          mem_re  = 1'b1;
          state_d = S_RBURST;
        end else begin
          lat_d = lat_q - 1'b1;
        end
      end
      S_RBURST: begin
        if (!stall) begin
          rvalid = 1'b1;
          beat_d = beat_q + 1'b1;
          if (beat_q == LAST_BEAT) state_d = S_DONE;
          else                     mem_re  = bus.req;
        end
        if (!bus.req) state_d = S_IDLE;
      end
      S_DONE: begin
        state_d = S_IDLE;
        beat_d  = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Reads run one beat ahead of the beat being presented; writes use the current beat.
  assign mem_beat = (state_q == S_RBURST) ? beat_q + 1'b1 : beat_q;
  assign mem_addr = WORD_BITS'(beat_word(32'(addr_q), mem_beat));

  sp_bram64 #(.AW(WORD_BITS)) u_bram (
    .clk     (clk),
    .rst     (rst),
    .we_i    (mem_we),
    .re_i    (mem_re),
    .addr_i  (mem_addr),
    .wdata_i (bus.wdata),
    .rdata_o (bus.rdata)
  );

  assign bus.ready  = ready;
  assign bus.rvalid = rvalid;
  assign bus.busy   = (state_q != S_IDLE);
endmodule
